// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared state codes, opcodes and instruction field positions
package instr_sequencer_pkg;

  // Sequencer state codes, also decoded by the datapath
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_EXEC  = 4'd1,
    ST_FETCH = 4'd2,
    ST_HALT  = 4'd3
  } state_e;

  // Opcodes
  localparam logic [7:0] OP_LIMM16 = 8'h02;
  localparam logic [7:0] OP_CP     = 8'hd2;
  localparam logic [7:0] OP_CPDR   = 8'hd3;
  localparam logic [7:0] OP_END    = 8'hff;
  localparam logic [7:0] OP_ALU_LO = 8'h10;
  localparam logic [7:0] OP_ALU_HI = 8'h19;

  // Instruction field positions
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 24;
  localparam int OPD0_MSB = 23;
  localparam int OPD0_LSB = 18;
  localparam int OPD1_MSB = 17;
  localparam int OPD1_LSB = 12;
  localparam int OPD2_MSB = 11;
  localparam int OPD2_LSB = 6;

  // Extract the opcode byte of an instruction word
  function automatic logic [7:0] get_op(input logic [31:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/execute sequencer with CPDR debug capture and PC overflow halt
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            pmem_req,
  output logic [PC_W-1:0] pmem_addr,
  input  logic [31:0]     pmem_rdata,
  input  logic            pmem_ack,
  output logic [31:0]     instr0,
  output logic [3:0]      current_state,
  input  logic [31:0]     ireg_d0,
  output logic [31:0]     dr,
  output logic            dr_valid,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            pc_ovf
);

  localparam logic [PC_W-1:0] PC_MAX = {PC_W{1'b1}};

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     dr_q, dr_d;
  logic            dr_valid_q, dr_valid_d;

  // Next-state logic: run only honoured when idle/halted, ack only in FETCH
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ovf_d      = ovf_q;
    instr_d    = instr_q;
    dr_d       = dr_q;
    dr_valid_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (run) begin
          pc_d    = '0;
          ovf_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (pmem_ack) begin
          instr_d = pmem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (get_op(instr_q) == OP_CPDR) begin
          dr_d       = ireg_d0;
          dr_valid_d = 1'b1;
        end
        if (get_op(instr_q) == OP_END) begin
          state_d = ST_HALT;
        end else if (pc_q == PC_MAX) begin
          // Running off the end of memory halts instead of wrapping
          ovf_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ovf_q      <= 1'b0;
      instr_q    <= '0;
      dr_q       <= '0;
      dr_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ovf_q      <= ovf_d;
      instr_q    <= instr_d;
      dr_q       <= dr_d;
      dr_valid_q <= dr_valid_d;
    end
  end

  assign pmem_req      = (state_q == ST_FETCH);
  assign pmem_addr     = pc_q;
  assign instr0        = instr_q;
  assign current_state = state_q;
  assign dr            = dr_q;
  assign dr_valid      = dr_valid_q;
  assign pc            = pc_q;
  assign halted        = (state_q == ST_HALT);
  assign pc_ovf        = ovf_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_EXEC  = 4'd1;
  localparam logic [3:0] S_FETCH = 4'd2;
  localparam logic [3:0] S_HALT  = 4'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        pmem_req;
  logic [9:0]  pmem_addr;
  logic [31:0] pmem_rdata = '0;
  logic        pmem_ack = 1'b0;
  logic [31:0] instr0;
  logic [3:0]  cur_state;
  logic [31:0] ireg_d0 = '0;
  logic [31:0] dr;
  logic        dr_valid;
  logic [9:0]  pc;
  logic        halted;
  logic        pc_ovf;

  logic        b_reset = 1'b1;
  logic        b_run = 1'b0;
  logic        b_req;
  logic [1:0]  b_addr;
  logic [31:0] b_rdata = '0;
  logic        b_ack = 1'b0;
  logic [31:0] b_instr0;
  logic [3:0]  b_state;
  logic [31:0] b_dr;
  logic        b_dr_valid;
  logic [1:0]  b_pc;
  logic        b_halted;
  logic        b_ovf;

  int checks = 0;
  int failures = 0;

  logic [31:0] prog [4];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          mem_en = 1'b1;

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(10)) dut (
    .clk(clk), .reset(reset), .run(run),
    .pmem_req(pmem_req), .pmem_addr(pmem_addr), .pmem_rdata(pmem_rdata), .pmem_ack(pmem_ack),
    .instr0(instr0), .current_state(cur_state), .ireg_d0(ireg_d0),
    .dr(dr), .dr_valid(dr_valid), .pc(pc), .halted(halted), .pc_ovf(pc_ovf)
  );

  instr_sequencer #(.PC_W(2)) dut_b (
    .clk(clk), .reset(b_reset), .run(b_run),
    .pmem_req(b_req), .pmem_addr(b_addr), .pmem_rdata(b_rdata), .pmem_ack(b_ack),
    .instr0(b_instr0), .current_state(b_state), .ireg_d0(32'h0),
    .dr(b_dr), .dr_valid(b_dr_valid), .pc(b_pc), .halted(b_halted), .pc_ovf(b_ovf)
  );

  // Program memory model for the main DUT with configurable ack latency
  always @(negedge clk) begin
    if (mem_en) begin
      if (pmem_req) begin
        if (wait_cnt == ack_delay) begin
          pmem_ack   = 1'b1;
          pmem_rdata = prog[pmem_addr[1:0]];
          wait_cnt   = 0;
        end else begin
          pmem_ack = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        pmem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Zero-wait all-NOP memory for the 2-bit PC instance
  always @(negedge clk) begin
    b_ack   = b_req;
    b_rdata = 32'h0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cur_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", cur_state, S_IDLE); end
    checks++; if (pc !== 10'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    checks++; if (instr0 !== 32'h0) begin failures++; $display("FAIL reset_instr0 got=%h exp=0", instr0); end
    checks++; if ({dr_valid, pmem_req, halted, pc_ovf} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {dr_valid, pmem_req, halted, pc_ovf}); end
    checks++; if (dr !== 32'h0) begin failures++; $display("FAIL reset_dr got=%h exp=0", dr); end
    // ack outside FETCH must be ignored
    mem_en = 1'b0;
    pmem_ack = 1'b1;
    pmem_rdata = 32'hffffffff;
    step();
    checks++; if (cur_state !== S_IDLE || instr0 !== 32'h0) begin failures++; $display("FAIL idle_ack_ignored got state=%0d instr0=%h exp state=0 instr0=0", cur_state, instr0); end
    pmem_ack = 1'b0;
    step();
    mem_en = 1'b1;
  endtask

  task automatic test_program();
    logic [3:0] exp_st [5] = '{S_FETCH, S_EXEC, S_FETCH, S_EXEC, S_HALT};
    do_reset();
    prog[0] = 32'h02040005;
    prog[1] = 32'hff000000;
    ack_delay = 0;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      run = 1'b0;
      checks++; if (cur_state !== exp_st[i]) begin failures++; $display("FAIL prog_seq step=%0d got=%0d exp=%0d", i, cur_state, exp_st[i]); end
      if (i == 0) begin
        checks++; if (pmem_req !== 1'b1 || pmem_addr !== 10'd0) begin failures++; $display("FAIL prog_fetch0 got req=%b addr=%0d exp req=1 addr=0", pmem_req, pmem_addr); end
      end
      if (i == 2) begin
        checks++; if (pmem_req !== 1'b1 || pmem_addr !== 10'd1) begin failures++; $display("FAIL prog_fetch1 got req=%b addr=%0d exp req=1 addr=1", pmem_req, pmem_addr); end
      end
      if (i == 1) begin
        checks++; if (instr0 !== 32'h02040005) begin failures++; $display("FAIL prog_instr0 got=%h exp=02040005", instr0); end
      end
    end
    checks++; if (halted !== 1'b1 || pc !== 10'd1 || pmem_req !== 1'b0) begin failures++; $display("FAIL prog_halt got halted=%b pc=%0d req=%b exp 1 1 0", halted, pc, pmem_req); end
  endtask

  task automatic test_wait_states();
    do_reset();
    prog[0] = 32'h12345678;
    prog[1] = 32'hff000000;
    ack_delay = 3;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      run = 1'b0;
      checks++; if (cur_state !== S_FETCH || pmem_req !== 1'b1 || pmem_addr !== 10'd0 || instr0 !== 32'h0) begin
        failures++; $display("FAIL wait_hold cyc=%0d got state=%0d req=%b addr=%0d instr0=%h exp 2 1 0 0", i, cur_state, pmem_req, pmem_addr, instr0);
      end
    end
    step();
    checks++; if (cur_state !== S_EXEC || instr0 !== 32'h12345678) begin failures++; $display("FAIL wait_exec got state=%0d instr0=%h exp 1 12345678", cur_state, instr0); end
    step();
    checks++; if (cur_state !== S_FETCH || pc !== 10'd1 || instr0 !== 32'h12345678) begin failures++; $display("FAIL wait_next got state=%0d pc=%0d instr0=%h exp 2 1 12345678", cur_state, pc, instr0); end
    for (int i = 0; i < 20 && !halted; i++) step();
    checks++; if (halted !== 1'b1 || pc !== 10'd1) begin failures++; $display("FAIL wait_halt got halted=%b pc=%0d exp 1 1", halted, pc); end
    ack_delay = 0;
  endtask

  task automatic test_cpdr();
    do_reset();
    prog[0] = 32'hd3001000;
    prog[1] = 32'hff000000;
    ireg_d0 = 32'hdeadbeef;
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    checks++; if (cur_state !== S_EXEC || dr_valid !== 1'b0 || dr !== 32'h0) begin failures++; $display("FAIL cpdr_exec got state=%0d dr_valid=%b dr=%h exp 1 0 0", cur_state, dr_valid, dr); end
    step();
    ireg_d0 = 32'h11111111;
    checks++; if (dr !== 32'hdeadbeef || dr_valid !== 1'b1) begin failures++; $display("FAIL cpdr_load got dr=%h dr_valid=%b exp deadbeef 1", dr, dr_valid); end
    step();
    checks++; if (dr !== 32'hdeadbeef || dr_valid !== 1'b0) begin failures++; $display("FAIL cpdr_pulse got dr=%h dr_valid=%b exp deadbeef 0", dr, dr_valid); end
    step();
    checks++; if (halted !== 1'b1 || dr !== 32'hdeadbeef) begin failures++; $display("FAIL cpdr_hold got halted=%b dr=%h exp 1 deadbeef", halted, dr); end
  endtask

  task automatic test_run_ignored_and_reset_ack();
    do_reset();
    prog[0] = 32'h00000000;
    prog[1] = 32'hff000000;
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    run = 1'b1;
    step();
    run = 1'b0;
    checks++; if (cur_state !== S_FETCH || pc !== 10'd1) begin failures++; $display("FAIL run_in_exec got state=%0d pc=%0d exp 2 1", cur_state, pc); end
    run = 1'b1;
    mem_en = 1'b0;
    pmem_ack = 1'b1;
    pmem_rdata = 32'hcafef00d;
    reset = 1'b1;
    step();
    reset = 1'b0;
    pmem_ack = 1'b0;
    run = 1'b0;
    checks++; if (cur_state !== S_IDLE || instr0 !== 32'h0 || pmem_req !== 1'b0 || pc !== 10'd0) begin
      failures++; $display("FAIL reset_over_ack got state=%0d instr0=%h req=%b pc=%0d exp 0 0 0 0", cur_state, instr0, pmem_req, pc);
    end
    step();
    mem_en = 1'b1;
    // Restart from HALT behaves like IDLE
    run = 1'b1;
    step();
    run = 1'b0;
    for (int i = 0; i < 20 && !halted; i++) step();
    run = 1'b1;
    step();
    run = 1'b0;
    checks++; if (cur_state !== S_FETCH || pc !== 10'd0) begin failures++; $display("FAIL halt_restart got state=%0d pc=%0d exp 2 0", cur_state, pc); end
  endtask

  task automatic test_overflow();
    bit early_ovf = 1'b0;
    bit pc_back = 1'b0;
    logic [1:0] prev_pc = 2'd0;
    b_reset = 1'b1;
    step();
    b_reset = 1'b0;
    b_run = 1'b1;
    step();
    b_run = 1'b0;
    for (int i = 0; i < 40 && !b_halted; i++) begin
      if (b_ovf) early_ovf = 1'b1;
      if (b_pc < prev_pc) pc_back = 1'b1;
      prev_pc = b_pc;
      step();
    end
    checks++; if (early_ovf || pc_back) begin failures++; $display("FAIL ovf_progress got early_ovf=%b pc_back=%b exp 0 0", early_ovf, pc_back); end
    checks++; if (b_halted !== 1'b1 || b_ovf !== 1'b1 || b_pc !== 2'd3 || b_state !== S_HALT) begin
      failures++; $display("FAIL ovf_halt got halted=%b ovf=%b pc=%0d state=%0d exp 1 1 3 3", b_halted, b_ovf, b_pc, b_state);
    end
    b_run = 1'b1;
    step();
    b_run = 1'b0;
    checks++; if (b_state !== S_FETCH || b_pc !== 2'd0 || b_ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_rerun got state=%0d pc=%0d ovf=%b exp 2 0 0", b_state, b_pc, b_ovf);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) prog[i] = 32'hff000000;
    test_reset();
    test_program();
    test_wait_states();
    test_cpdr();
    test_run_ignored_and_reset_ack();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
